// File: rtl/tpu_pkg.sv
// Shared types and helpers for the tpu_mm_engine slice.
// sat_add is only referenced when TPU_SAT_EN is defined.
package tpu_pkg;

   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, OUT} state_t;

   localparam int TPU_N_DEFAULT = 4;

   typedef struct packed {
      logic              sat;
      logic signed [63:0] sum;
   } sat_res_t;

   function automatic int tpu_drain_cycles(input int n);
      return 2 * n - 1;
   endfunction

   // Operands arrive sign-extended to 64 bits; aw selects the clamp range.
   function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                        input logic signed [63:0] b,
                                        input int unsigned        aw);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      s  = a + b;
      hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      r.sat = (s > hi) || (s < lo);
      r.sum = (s > hi) ? hi : ((s < lo) ? lo : s);
      return r;
   endfunction

endpackage

// File: rtl/tpu_pe.sv
// One weight-stationary MAC cell: stationary weight, activation pass-through, psum register.
// With TPU_SAT_EN the add clamps to the AW range and reports each clamp on sat_o.
module tpu_pe
   import tpu_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic                 w_load_i,
   input  logic signed [DW-1:0] w_i,
   input  logic signed [DW-1:0] a_i,
   input  logic signed [AW-1:0] psum_i,
   output logic signed [DW-1:0] a_o,
   output logic signed [AW-1:0] psum_o
`ifdef TPU_SAT_EN
   ,
   output logic                 sat_o
`endif
);

   logic signed [DW-1:0]   w_q;
   logic signed [DW-1:0]   a_q;
   logic signed [AW-1:0]   psum_q;
   logic signed [AW-1:0]   psum_d;
   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]   prod_ext;

   assign prod     = a_i * w_q;
   assign prod_ext = AW'(prod);

`ifdef TPU_SAT_EN
   sat_res_t res;

   always_comb begin
      res    = sat_add(64'(psum_i), 64'(prod_ext), AW);
      psum_d = res.sum[AW-1:0];
   end

   assign sat_o = en_i & res.sat;
`else
   assign psum_d = psum_i + prod_ext;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_q    <= '0;
         a_q    <= '0;
         psum_q <= '0;
      end else begin
         if (clr_i) begin
            w_q    <= '0;
            a_q    <= '0;
            psum_q <= '0;
         end else if (en_i) begin
            a_q    <= a_i;
            psum_q <= psum_d;
         end
         if (w_load_i) begin
            w_q <= w_i;
         end
      end
   end

   assign a_o    = a_q;
   assign psum_o = psum_q;

endmodule

// File: rtl/tpu_mm_engine.sv
// NxN weight-stationary matmul engine C = A x W with row-stream handshakes and a start/done sequencer.
// Define TPU_SAT_EN for clamping accumulation and the sticky sat flag; otherwise sums wrap.
module tpu_mm_engine
   import tpu_pkg::*;
#(
   parameter int N  = TPU_N_DEFAULT,
   parameter int DW = 8,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic          w_valid,
   output logic          w_ready,
   input  logic [N*DW-1:0] w_data,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [N*DW-1:0] a_data,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [N*AW-1:0] o_data,
   output logic          sat
);

   localparam int DRAIN_CYCLES = tpu_drain_cycles(N);
   localparam int CW           = $clog2(DRAIN_CYCLES + 1);
   localparam int RW           = $clog2(N);
   localparam int SW           = $clog2(3 * N);

   state_t         state_q;
   state_t         state_d;
   logic [CW-1:0]  cnt_q;
   logic [CW-1:0]  cnt_d;
   logic [SW-1:0]  step_q;
   logic           done_q;
   logic           done_d;
   logic           w_fire;
   logic           a_fire;
   logic           o_fire;
   logic           start_go;
   logic           advance;
   logic [RW-1:0]  row_idx;

   logic signed [DW-1:0] act  [N][N+1];
   logic signed [AW-1:0] psum [N+1][N];
   logic signed [AW-1:0] res_q [N][N];

   assign busy     = (state_q != IDLE);
   assign w_ready  = (state_q == LOAD_W);
   assign a_ready  = (state_q == STREAM);
   assign o_valid  = (state_q == OUT);
   assign done     = done_q;
   assign w_fire   = w_valid & w_ready;
   assign a_fire   = a_valid & a_ready;
   assign o_fire   = o_valid & o_ready;
   assign start_go = (state_q == IDLE) & start;
   assign advance  = a_fire | (state_q == DRAIN);
   assign row_idx  = cnt_q[RW-1:0];

   // cnt_q is the row counter in LOAD_W/STREAM/OUT and the cycle counter in DRAIN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_W;
               cnt_d   = '0;
            end
         end
         LOAD_W: begin
            if (w_fire) begin
               cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) state_d = STREAM;
            end
         end
         STREAM: begin
            if (a_fire) begin
               cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            cnt_d = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
            if (cnt_q == CW'(DRAIN_CYCLES - 1)) state_d = OUT;
         end
         OUT: begin
            if (o_fire) begin
               cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         step_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (start_go) begin
            step_q <= '0;
         end else if (advance) begin
            step_q <= step_q + SW'(1);
         end
      end
   end

   // Lane i enters PE row i delayed by i array steps; DRAIN feeds zeros.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic signed [DW-1:0] lane_in;
      assign lane_in = (state_q == STREAM) ? a_data[i*DW +: DW] : '0;
      if (i == 0) begin : g_direct
         assign act[i][0] = lane_in;
      end else begin : g_delay
         logic signed [DW-1:0] sk_q [i];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int k = 0; k < i; k++) sk_q[k] <= '0;
            end else if (start_go) begin
               for (int k = 0; k < i; k++) sk_q[k] <= '0;
            end else if (advance) begin
               sk_q[0] <= lane_in;
               for (int k = 1; k < i; k++) sk_q[k] <= sk_q[k-1];
            end
         end
         assign act[i][0] = sk_q[i-1];
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_top
      assign psum[0][j] = '0;
   end

`ifdef TPU_SAT_EN
   logic [N*N-1:0] pe_sat;
   logic           sat_q;
`endif

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         tpu_pe #(
            .DW(DW),
            .AW(AW)
         ) u_pe (
            .clk      (clk),
            .reset    (reset),
            .en_i     (advance),
            .clr_i    (start_go),
            .w_load_i (w_fire && (cnt_q == CW'(i))),
            .w_i      (w_data[j*DW +: DW]),
            .a_i      (act[i][j]),
            .psum_i   (psum[i][j]),
            .a_o      (act[i][j+1]),
            .psum_o   (psum[i+1][j])
`ifdef TPU_SAT_EN
            ,
            .sat_o    (pe_sat[i*N + j])
`endif
         );
      end
   end

   // After r+j+N advances the bottom of column j holds C[r][j].
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
               res_q[r][j] <= '0;
      end else if ((state_q == STREAM) || (state_q == DRAIN)) begin
         for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
               if (int'(step_q) == r + j + N) res_q[r][j] <= psum[N][j];
      end
   end

   always_comb begin
      o_data = '0;
      if (state_q == OUT) begin
         for (int j = 0; j < N; j++) o_data[j*AW +: AW] = res_q[row_idx][j];
      end
   end

`ifdef TPU_SAT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sat_q <= 1'b0;
      end else if (start_go) begin
         sat_q <= 1'b0;
      end else if (|pe_sat) begin
         sat_q <= 1'b1;
      end
   end

   assign sat = sat_q;
`else
   assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_mm_engine.sv
// Testbench for tpu_mm_engine: an N=2 instance for most scenarios and an N=4 instance for overflow.
// Expected results come from a plain matrix-multiply model with wrap or clamp arithmetic.
`timescale 1ns/1ps
module tb_tpu_mm_engine;

   localparam int DW   = 8;
   localparam int AW   = 16;
   localparam int AMAX = (1 <<< (AW - 1)) - 1;
   localparam int AMIN = -(1 <<< (AW - 1));

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic sel   = 1'b0;
   logic wValid = 1'b0;
   logic aValid = 1'b0;
   logic oReady = 1'b1;
   logic [4*DW-1:0] wData = '0;
   logic [4*DW-1:0] aData = '0;

   logic busy2, done2, wReady2, aReady2, oValid2, sat2;
   logic busy4, done4, wReady4, aReady4, oValid4, sat4;
   logic [2*AW-1:0] oData2;
   logic [4*AW-1:0] oData4;

   logic busyM, doneM, wReadyM, aReadyM, oValidM, satM;
   logic [4*AW-1:0] oDataM;

   int matA [4][4];
   int matW [4][4];
   int expC [4][4];
   bit expSat;
   int nChecks = 0;
   int nFails = 0;
   int cyc = 0;
   int doneSeen = 0;
   int lastACyc = -1;
   int firstOCyc = -1;

   tpu_mm_engine #(.N(2), .DW(DW), .AW(AW)) dut2 (
      .clk     (clock),
      .reset   (reset),
      .start   (start & ~sel),
      .busy    (busy2),
      .done    (done2),
      .w_valid (wValid & ~sel),
      .w_ready (wReady2),
      .w_data  (wData[2*DW-1:0]),
      .a_valid (aValid & ~sel),
      .a_ready (aReady2),
      .a_data  (aData[2*DW-1:0]),
      .o_valid (oValid2),
      .o_ready (oReady),
      .o_data  (oData2),
      .sat     (sat2)
   );

   tpu_mm_engine #(.N(4), .DW(DW), .AW(AW)) dut4 (
      .clk     (clock),
      .reset   (reset),
      .start   (start & sel),
      .busy    (busy4),
      .done    (done4),
      .w_valid (wValid & sel),
      .w_ready (wReady4),
      .w_data  (wData),
      .a_valid (aValid & sel),
      .a_ready (aReady4),
      .a_data  (aData),
      .o_valid (oValid4),
      .o_ready (oReady),
      .o_data  (oData4),
      .sat     (sat4)
   );

   assign busyM   = sel ? busy4   : busy2;
   assign doneM   = sel ? done4   : done2;
   assign wReadyM = sel ? wReady4 : wReady2;
   assign aReadyM = sel ? aReady4 : aReady2;
   assign oValidM = sel ? oValid4 : oValid2;
   assign satM    = sel ? sat4    : sat2;
   assign oDataM  = sel ? oData4  : {{(2*AW){1'b0}}, oData2};

   // Free-running clock, cycle counter and done-pulse counter.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) if (doneM === 1'b1) doneSeen <= doneSeen + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Reference: C[r][j] = sum_i A[r][i]*W[i][j], clamped per add or wrapped to AW bits.
   task automatic computeModel(input int n);
      longint acc;
      expSat = 1'b0;
      for (int r = 0; r < n; r++) begin
         for (int j = 0; j < n; j++) begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
               acc = acc + longint'(matA[r][i]) * longint'(matW[i][j]);
`ifdef TPU_SAT_EN
               if (acc > AMAX) begin acc = AMAX; expSat = 1'b1; end
               if (acc < AMIN) begin acc = AMIN; expSat = 1'b1; end
`endif
            end
`ifndef TPU_SAT_EN
            acc = longint'(shortint'(acc));
`endif
            expC[r][j] = int'(acc);
         end
      end
   endtask

   task automatic fillRandom(input int n, input int lo, input int hi);
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++) begin
            matA[r][c] = int'($urandom_range(0, hi - lo)) + lo;
            matW[r][c] = int'($urandom_range(0, hi - lo)) + lo;
         end
   endtask

   task automatic driveWeights(input int n, input bit toggle);
      int k = 0;
      int guard = 0;
      bit fire;
      while (k < n && guard < 100) begin
         wValid = !toggle || (guard % 2 == 1);
         wData = '0;
         for (int j = 0; j < n; j++) wData[j*DW +: DW] = DW'(matW[k][j]);
         @(negedge clock);
         fire = wValid && wReadyM;
         @(posedge clock); #1;
         if (fire) k++;
         guard++;
      end
      wValid = 1'b0;
      nChecks++;
      if (k != n) begin
         nFails++;
         $display("[TB] FAIL weightBeats: accepted %0d, required %0d", k, n);
      end
   endtask

   task automatic driveActs(input int n, input bit toggle, input int limit);
      int k = 0;
      int guard = 0;
      bit fire;
      while (k < limit && guard < 100) begin
         aValid = !toggle || (guard % 2 == 1);
         aData = '0;
         for (int i = 0; i < n; i++) aData[i*DW +: DW] = DW'(matA[k][i]);
         @(negedge clock);
         fire = aValid && aReadyM;
         if (fire) lastACyc = cyc;
         @(posedge clock); #1;
         if (fire) k++;
         guard++;
      end
      aValid = 1'b0;
      nChecks++;
      if (k != limit) begin
         nFails++;
         $display("[TB] FAIL actBeats: accepted %0d, required %0d", k, limit);
      end
   endtask

   // Every sampled o_valid row (stalled or accepted) must equal the model row.
   task automatic collectOutputs(input int n, input int stall, input bit randReady);
      int r = 0;
      int guard = 0;
      int stallLeft = stall;
      int lane;
      firstOCyc = -1;
      while (r < n && guard < 200) begin
         if (r == 0 && stallLeft > 0 && oValidM) begin
            oReady = 1'b0;
            stallLeft--;
         end else if (randReady) begin
            oReady = ($urandom_range(0, 3) != 0);
         end else begin
            oReady = 1'b1;
         end
         @(negedge clock);
         if (oValidM === 1'b1) begin
            if (firstOCyc < 0) firstOCyc = cyc;
            for (int j = 0; j < n; j++) begin
               lane = int'(signed'(oDataM[j*AW +: AW]));
               nChecks++;
               if (lane != expC[r][j]) begin
                  nFails++;
                  $display("[TB] FAIL row%0d lane%0d: got %0d, expected %0d (ready=%0b)",
                           r, j, lane, expC[r][j], oReady);
               end
            end
            if (oReady) r++;
         end
         @(posedge clock); #1;
         guard++;
      end
      oReady = 1'b1;
      nChecks++;
      if (r != n) begin
         nFails++;
         $display("[TB] FAIL outputBeats: accepted %0d, required %0d", r, n);
      end
   endtask

   // startMode: 0 pulse start, 1 raise and leave high, 2 already high and lowered after weights.
   task automatic applyStimulus(input int n, input bit toggle, input int stall,
                                input bit randReady, input int startMode);
      int d0;
      computeModel(n);
      d0 = doneSeen;
      if (startMode == 0) begin
         start = 1'b1;
         @(posedge clock); #1;
         start = 1'b0;
      end else if (startMode == 1) begin
         start = 1'b1;
         @(posedge clock); #1;
      end
      driveWeights(n, toggle);
      if (startMode == 2) start = 1'b0;
      driveActs(n, toggle, n);
      collectOutputs(n, stall, randReady);
      nChecks++;
      if (firstOCyc - lastACyc != 2 * n) begin
         nFails++;
         $display("[TB] FAIL latency: got %0d cycles, expected %0d", firstOCyc - lastACyc, 2 * n);
      end
      @(negedge clock);
      nChecks++;
      if (doneM !== 1'b1 || busyM !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL doneBusy: done=%0b busy=%0b, expected done=1 busy=0", doneM, busyM);
      end
      nChecks++;
      if (satM !== expSat) begin
         nFails++;
         $display("[TB] FAIL sat: got %0b, expected %0b", satM, expSat);
      end
      @(posedge clock); #1;
      nChecks++;
      if (doneSeen != d0 + 1) begin
         nFails++;
         $display("[TB] FAIL doneCount: got %0d pulses, expected 1", doneSeen - d0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      nChecks++;
      if ({busy2, done2, wReady2, aReady2, oValid2, sat2} !== 6'b0) begin
         nFails++;
         $display("[TB] FAIL resetFlags2: got %b, expected 000000",
                  {busy2, done2, wReady2, aReady2, oValid2, sat2});
      end
      nChecks++;
      if ({busy4, done4, wReady4, aReady4, oValid4, sat4} !== 6'b0) begin
         nFails++;
         $display("[TB] FAIL resetFlags4: got %b, expected 000000",
                  {busy4, done4, wReady4, aReady4, oValid4, sat4});
      end
      nChecks++;
      if (oData2 !== '0 || oData4 !== '0) begin
         nFails++;
         $display("[TB] FAIL resetData: got %h / %h, expected 0", oData2, oData4);
      end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_identity();
      sel = 1'b0;
      matW[0][0] = 1; matW[0][1] = 0; matW[1][0] = 0; matW[1][1] = 1;
      matA[0][0] = 1; matA[0][1] = 2; matA[1][0] = 3; matA[1][1] = 4;
      applyStimulus(2, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic test_general();
      sel = 1'b0;
      matW[0][0] = 5; matW[0][1] = 6; matW[1][0] = 7; matW[1][1] = 8;
      matA[0][0] = 1; matA[0][1] = 2; matA[1][0] = 3; matA[1][1] = 4;
      applyStimulus(2, 1'b0, 0, 1'b0, 0);
      matA[0][0] = -1; matA[0][1] = 2; matA[1][0] = 3; matA[1][1] = -4;
      applyStimulus(2, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      matW[0][0] = 5; matW[0][1] = 6; matW[1][0] = 7; matW[1][1] = 8;
      matA[0][0] = 1; matA[0][1] = 2; matA[1][0] = 3; matA[1][1] = 4;
      applyStimulus(2, 1'b1, 3, 1'b0, 0);
   endtask

   task automatic test_overflow();
      sel = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            matA[r][c] = 127;
            matW[r][c] = 127;
         end
      applyStimulus(4, 1'b0, 0, 1'b0, 0);
      fillRandom(4, -8, 8);
      applyStimulus(4, 1'b1, 2, 1'b1, 0);
      sel = 1'b0;
   endtask

   task automatic test_reset_mid_stream();
      sel = 1'b0;
      fillRandom(2, -128, 127);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      driveWeights(2, 1'b0);
      driveActs(2, 1'b0, 1);
      #2 reset = 1'b0;
      #1;
      nChecks++;
      if (busyM !== 1'b0 || oValidM !== 1'b0 || aReadyM !== 1'b0) begin
         nFails++;
         $display("[TB] FAIL asyncReset: busy=%0b o_valid=%0b a_ready=%0b, expected all 0",
                  busyM, oValidM, aReadyM);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      fillRandom(2, -128, 127);
      applyStimulus(2, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic test_start_held();
      int d0;
      sel = 1'b0;
      fillRandom(2, -128, 127);
      applyStimulus(2, 1'b0, 0, 1'b0, 1);
      nChecks++;
      if (busyM !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL restartBusy: got %0b, expected 1", busyM);
      end
      fillRandom(2, -128, 127);
      applyStimulus(2, 1'b0, 0, 1'b0, 2);
      d0 = doneSeen;
      repeat (3) @(posedge clock);
      #1;
      nChecks++;
      if (busyM !== 1'b0 || doneSeen != d0) begin
         nFails++;
         $display("[TB] FAIL idleAfterRelease: busy=%0b extraDone=%0d, expected 0 and 0",
                  busyM, doneSeen - d0);
      end
   endtask

   task automatic test_random();
      sel = 1'b0;
      for (int t = 0; t < 6; t++) begin
         fillRandom(2, -128, 127);
         applyStimulus(2, 1'(t % 2), int'($urandom_range(0, 3)), 1'b1, 0);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_general();
      test_backpressure();
      test_overflow();
      test_reset_mid_stream();
      test_start_held();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
